link_tx_pattern_gen: RTL and testbench

Parametrised link test-pattern transmitter. It generates a framed word stream on the parallel PCS link for bring-up and BER checks. Each frame is PERIOD words long and starts with a marker word. The payload is selectable: counter ramp, PRBS7, fixed word or walking-one. The block sits directly ahead of the PCS serializer input and replaces the fixed 20-bit / 2000-word ramp generator.

---
 rtl/link_tx_pattern_gen_if.sv | 64 ++++++
 rtl/link_tx_pattern_gen.sv | 189 ++++++++++++++++++
 tb/tb_link_tx_pattern_gen.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/link_tx_pattern_gen_if.sv
// -----------------------------------------------------------------------------
// link_tx_pattern_gen_if
//
// Purpose: bundles the control inputs and the generated link word stream of
// the link test-pattern transmitter so that the generator and whatever drives
// or consumes it share one connection.
//
// Parameters:
//   DW         link word width
//
// Signals:
//   iEn        generator enable; low = idle/hold
//   iMode[1:0] payload mode: 0 ramp, 1 PRBS7, 2 fixed, 3 walking-one
//   iFixed     payload word for the fixed mode
//   oD_Link    link word
//   oValid     oD_Link carries a generated word
//   oSof       high together with the frame marker word
//   oFrameCnt  frames sent, wraps
//   iErrInj    error-inject request  (LINK_TX_ERR_INJ_EN builds only)
//   oErrCnt    injected errors, wraps (LINK_TX_ERR_INJ_EN builds only)
//
// Modports:
//   master     the pattern generator itself
//   slave      the controller / consumer side
//
// Build option: define LINK_TX_ERR_INJ_EN to add the error-injection signals.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

interface link_tx_pattern_gen_if #(
    parameter int DW = 20
);
    logic          iEn;
    logic [1:0]    iMode;
    logic [DW-1:0] iFixed;
    logic [DW-1:0] oD_Link;
    logic          oValid;
    logic          oSof;
    logic [15:0]   oFrameCnt;
`ifdef LINK_TX_ERR_INJ_EN
    logic          iErrInj;
    logic [15:0]   oErrCnt;

    modport master (
        input  iEn, iMode, iFixed, iErrInj,
        output oD_Link, oValid, oSof, oFrameCnt, oErrCnt
    );

    modport slave (
        output iEn, iMode, iFixed, iErrInj,
        input  oD_Link, oValid, oSof, oFrameCnt, oErrCnt
    );
`else
    modport master (
        input  iEn, iMode, iFixed,
        output oD_Link, oValid, oSof, oFrameCnt
    );

    modport slave (
        output iEn, iMode, iFixed,
        input  oD_Link, oValid, oSof, oFrameCnt
    );
`endif
endinterface

// File: rtl/link_tx_pattern_gen.sv
// -----------------------------------------------------------------------------
// link_tx_pattern_gen
//
// Purpose: parametrised link test-pattern transmitter for bring-up and BER
// checks. It emits a framed word stream towards the PCS serializer: every
// frame is PERIOD words long, begins with the MARKER word, and the remaining
// words carry a selectable payload (counter ramp, PRBS7, fixed word or
// walking-one).
//
// Parameters:
//   DW      link word width (>= 8)
//   PERIOD  words per frame, marker included (>= 2)
//   CW      frame position counter width, 2^CW >= PERIOD
//   SHIFT   left shift of the position in the ramp payload, CW+SHIFT <= DW
//   MARKER  frame marker word
//
// Ports:
//   iPclk   link parallel clock
//   iRst    synchronous active-high reset
//   link    link_tx_pattern_gen_if.master (enable, mode, fixed word in;
//           link word, valid, start-of-frame, frame count out; plus the
//           error-inject request and error count when enabled)
//
// Build option: define LINK_TX_ERR_INJ_EN to build the single-bit error
// injector (iErrInj / oErrCnt). Without it no injection logic exists and the
// stream equals the injector build with iErrInj held low.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module link_tx_pattern_gen #(
    parameter int            DW     = 20,
    parameter int            PERIOD = 2000,
    parameter int            CW     = 12,
    parameter int            SHIFT  = 4,
    parameter logic [DW-1:0] MARKER = 20'hFFFFF
) (
    input  logic                  iPclk,
    input  logic                  iRst,
    link_tx_pattern_gen_if.master link
);

    // Payload modes as latched at the frame boundary.
    localparam logic [1:0] MODE_RAMP  = 2'd0;
    localparam logic [1:0] MODE_PRBS  = 2'd1;
    localparam logic [1:0] MODE_FIXED = 2'd2;
    localparam logic [1:0] MODE_WALK  = 2'd3;

    localparam int            WW        = $clog2(DW);
    localparam logic [CW-1:0] LAST_POS  = CW'(PERIOD - 1);
    localparam logic [WW-1:0] WALK_LAST = WW'(DW - 1);
    localparam logic [6:0]    LFSR_SEED = 7'h7F;
    localparam logic [DW-1:0] ONE_LSB   = {{(DW-1){1'b0}}, 1'b1};

    // Frame position, latched mode and payload generator state.
    logic [CW-1:0] pos;
    logic [1:0]    active_mode;
    logic [6:0]    lfsr;
    logic [WW-1:0] walk_pos;

    // Registered outputs.
    logic [DW-1:0] d_link;
    logic          valid;
    logic          sof;
    logic [15:0]   frame_cnt;

    // Combinational helpers.
    logic          is_marker;
    logic [CW-1:0] pos_next;
    logic [WW-1:0] walk_next;
    logic [DW-1:0] ramp_word;
    logic [DW-1:0] walk_word;
    logic [DW-1:0] prbs_word;
    logic [6:0]    lfsr_adv;
    logic [6:0]    prbs_state;
    logic          prbs_bit;
    logic [DW-1:0] payload;
    logic [DW-1:0] payload_out;

    assign is_marker = (pos == '0);
    assign pos_next  = (pos == LAST_POS) ? '0 : pos + CW'(1);

    // walk_pos tracks (pos-1) mod DW without a divider: it restarts at the
    // marker and steps once per payload word, wrapping at DW.
    assign walk_next = (walk_pos == WALK_LAST) ? '0 : walk_pos + WW'(1);

    assign ramp_word = DW'(pos) << SHIFT;
    assign walk_word = ONE_LSB << walk_pos;

    // PRBS7 (x^7 + x^6 + 1, Fibonacci) unrolled DW steps per word. Each step's
    // feedback bit is both the output bit and the bit shifted into the
    // register; the first bit produced lands in the word MSB.
    always_comb begin
        prbs_word  = '0;
        prbs_state = lfsr;
        prbs_bit   = 1'b0;
        for (int i = DW - 1; i >= 0; i--) begin
            prbs_bit     = prbs_state[6] ^ prbs_state[5];
            prbs_word[i] = prbs_bit;
            prbs_state   = {prbs_state[5:0], prbs_bit};
        end
        lfsr_adv = prbs_state;
    end

    // Payload selection uses the mode latched at the last marker, so a mode
    // change on iMode only shows up in the next frame.
    always_comb begin
        payload = ramp_word;
        case (active_mode)
            MODE_RAMP:  payload = ramp_word;
            MODE_PRBS:  payload = prbs_word;
            MODE_FIXED: payload = link.iFixed;
            MODE_WALK:  payload = walk_word;
            default:    payload = ramp_word;
        endcase
    end

`ifdef LINK_TX_ERR_INJ_EN
    logic        err_pending;
    logic [15:0] err_cnt;
    logic        inject_now;

    // A pending request is consumed by the next enabled payload word; marker
    // edges and idle edges leave it waiting.
    assign inject_now  = err_pending && link.iEn && !is_marker;
    assign payload_out = payload ^ {{(DW-1){1'b0}}, inject_now};

    // Requests arriving while one is already pending collapse into it. A
    // request on the very edge that consumes the pending flag is a fresh
    // request and re-arms the flag.
    always_ff @(posedge iPclk) begin
        if (iRst) begin
            err_pending <= 1'b0;
            err_cnt     <= '0;
        end else if (inject_now) begin
            err_pending <= link.iErrInj;
            err_cnt     <= err_cnt + 16'd1;
        end else if (link.iErrInj) begin
            err_pending <= 1'b1;
        end
    end

    assign link.oErrCnt = err_cnt;
`else
    assign payload_out = payload;
`endif

    // Main sequencer. Position 0 emits the marker, latches the mode and
    // reseeds the payload generators; all other positions emit payload. When
    // disabled the outputs go quiet while position, LFSR and frame count hold,
    // so re-enabling continues mid-frame.
    always_ff @(posedge iPclk) begin
        if (iRst) begin
            pos         <= '0;
            active_mode <= MODE_RAMP;
            lfsr        <= LFSR_SEED;
            walk_pos    <= '0;
            d_link      <= '0;
            valid       <= 1'b0;
            sof         <= 1'b0;
            frame_cnt   <= '0;
        end else if (link.iEn) begin
            pos   <= pos_next;
            valid <= 1'b1;
            if (is_marker) begin
                d_link      <= MARKER;
                sof         <= 1'b1;
                frame_cnt   <= frame_cnt + 16'd1;
                active_mode <= link.iMode;
                lfsr        <= LFSR_SEED;
                walk_pos    <= '0;
            end else begin
                d_link   <= payload_out;
                sof      <= 1'b0;
                lfsr     <= lfsr_adv;
                walk_pos <= walk_next;
            end
        end else begin
            d_link <= '0;
            valid  <= 1'b0;
            sof    <= 1'b0;
        end
    end

    assign link.oD_Link   = d_link;
    assign link.oValid    = valid;
    assign link.oSof      = sof;
    assign link.oFrameCnt = frame_cnt;

endmodule

// File: tb/tb_link_tx_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_link_tx_pattern_gen
//
// Purpose: self-checking bench for link_tx_pattern_gen. One DUT uses the
// default parameters; a second one uses PERIOD=2 to cover the shortest frame.
// Define LINK_TX_ERR_INJ_EN to also exercise the error injector.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_link_tx_pattern_gen;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    link_tx_pattern_gen_if #(.DW(20)) link  ();
    link_tx_pattern_gen_if #(.DW(20)) link2 ();

    link_tx_pattern_gen #(
        .DW(20), .PERIOD(2000), .CW(12), .SHIFT(4), .MARKER(20'hFFFFF)
    ) dut (
        .iPclk(clk),
        .iRst (rst),
        .link (link)
    );

    link_tx_pattern_gen #(
        .DW(20), .PERIOD(2), .CW(1), .SHIFT(4), .MARKER(20'hFFFFF)
    ) dut2 (
        .iPclk(clk),
        .iRst (rst),
        .link (link2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so a stuck run still terminates.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired got=timeout exp=finish");
        $fatal(1, "[TB] watchdog");
    end

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        link.iEn     = 1'b1;
        link.iMode   = 2'd0;
        link.iFixed  = '0;
        tick();
        checks++;
        if (link.oD_Link !== 20'h0) begin
            failures++;
            $display("[TB] FAIL reset_data got=%h exp=%h", link.oD_Link, 20'h0);
        end
        checks++;
        if (link.oValid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_valid got=%b exp=0", link.oValid);
        end
        checks++;
        if (link.oSof !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_sof got=%b exp=0", link.oSof);
        end
        checks++;
        if (link.oFrameCnt !== 16'd0) begin
            failures++;
            $display("[TB] FAIL reset_frame_cnt got=%0d exp=0", link.oFrameCnt);
        end
`ifdef LINK_TX_ERR_INJ_EN
        checks++;
        if (link.oErrCnt !== 16'd0) begin
            failures++;
            $display("[TB] FAIL reset_err_cnt got=%0d exp=0", link.oErrCnt);
        end
`endif
        rst = 1'b0;
    endtask

    // Plan item 1: ramp frame, marker, second marker and frame count.
    task automatic test_ramp();
        logic [19:0] exp_word;
        logic        exp_sof;
        link.iEn   = 1'b0;
        link.iMode = 2'd0;
        do_reset();
        link.iEn = 1'b1;
        for (int k = 0; k <= 2000; k++) begin
            exp_word = (k % 2000 == 0) ? 20'hFFFFF : 20'((k % 2000) << 4);
            exp_sof  = (k % 2000 == 0);
            tick();
            checks++;
            if (link.oD_Link !== exp_word) begin
                failures++;
                $display("[TB] FAIL ramp_word k=%0d got=%h exp=%h", k, link.oD_Link, exp_word);
            end
            checks++;
            if (link.oSof !== exp_sof || link.oValid !== 1'b1) begin
                failures++;
                $display("[TB] FAIL ramp_flags k=%0d got sof=%b valid=%b exp sof=%b valid=1",
                         k, link.oSof, link.oValid, exp_sof);
            end
            if (k == 1999) begin
                checks++;
                if (link.oD_Link !== 20'h07CF0) begin
                    failures++;
                    $display("[TB] FAIL ramp_last got=%h exp=%h", link.oD_Link, 20'h07CF0);
                end
            end
            if (k == 0 || k == 2000) begin
                checks++;
                if (link.oFrameCnt !== 16'((k / 2000) + 1)) begin
                    failures++;
                    $display("[TB] FAIL ramp_frame_cnt k=%0d got=%0d exp=%0d",
                             k, link.oFrameCnt, (k / 2000) + 1);
                end
            end
        end
    endtask

    // Plan item 2: PRBS7 against a bit-serial model over three frames.
    task automatic test_prbs();
        bit          q[$];
        bit          nb;
        logic [19:0] exp_word;
        link.iEn   = 1'b0;
        link.iMode = 2'd1;
        do_reset();
        link.iEn = 1'b1;
        for (int k = 0; k < 3 * 2000; k++) begin
            if (k % 2000 == 0) begin
                q.delete();
                repeat (7) q.push_back(1'b1);
                exp_word = 20'hFFFFF;
            end else begin
                for (int b = 19; b >= 0; b--) begin
                    nb          = q[0] ^ q[1];
                    exp_word[b] = nb;
                    q.push_back(nb);
                    void'(q.pop_front());
                end
            end
            tick();
            checks++;
            if (link.oD_Link !== exp_word) begin
                failures++;
                $display("[TB] FAIL prbs_word k=%0d got=%h exp=%h", k, link.oD_Link, exp_word);
            end
            if (k == 1) begin
                checks++;
                if (link.oD_Link !== 20'h020C2) begin
                    failures++;
                    $display("[TB] FAIL prbs_first got=%h exp=%h", link.oD_Link, 20'h020C2);
                end
            end
        end
    endtask

    // Plan item 3: mode change mid-frame only applies at the next marker.
    task automatic test_mode_change();
        logic [19:0] exp_word;
        link.iEn    = 1'b0;
        link.iMode  = 2'd0;
        link.iFixed = 20'hA5A5A;
        do_reset();
        link.iEn = 1'b1;
        for (int k = 0; k < 4000; k++) begin
            if (k == 500) link.iMode = 2'd2;
            if (k % 2000 == 0)  exp_word = 20'hFFFFF;
            else if (k < 2000)  exp_word = 20'(k << 4);
            else                exp_word = 20'hA5A5A;
            tick();
            checks++;
            if (link.oD_Link !== exp_word) begin
                failures++;
                $display("[TB] FAIL mode_change k=%0d got=%h exp=%h", k, link.oD_Link, exp_word);
            end
        end
        // Marker, then a fixed word sampled on the edge it is emitted.
        tick();
        link.iFixed = 20'h12345;
        tick();
        checks++;
        if (link.oD_Link !== 20'h12345) begin
            failures++;
            $display("[TB] FAIL fixed_resample got=%h exp=%h", link.oD_Link, 20'h12345);
        end
    endtask

    // Plan item 4: enable gap holds position, no marker on resume.
    task automatic test_enable_hold();
        link.iEn   = 1'b0;
        link.iMode = 2'd0;
        do_reset();
        link.iEn = 1'b1;
        repeat (100) tick();
        link.iEn = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++;
            if (link.oValid !== 1'b0 || link.oD_Link !== 20'h0 || link.oSof !== 1'b0) begin
                failures++;
                $display("[TB] FAIL idle_out k=%0d got valid=%b data=%h sof=%b exp valid=0 data=00000 sof=0",
                         k, link.oValid, link.oD_Link, link.oSof);
            end
            checks++;
            if (link.oFrameCnt !== 16'd1) begin
                failures++;
                $display("[TB] FAIL idle_frame_cnt got=%0d exp=1", link.oFrameCnt);
            end
        end
        link.iEn = 1'b1;
        tick();
        checks++;
        if (link.oD_Link !== 20'h00640 || link.oValid !== 1'b1 || link.oSof !== 1'b0) begin
            failures++;
            $display("[TB] FAIL resume_word got data=%h valid=%b sof=%b exp data=00640 valid=1 sof=0",
                     link.oD_Link, link.oValid, link.oSof);
        end
        tick();
        checks++;
        if (link.oD_Link !== 20'h00650) begin
            failures++;
            $display("[TB] FAIL resume_next got=%h exp=%h", link.oD_Link, 20'h00650);
        end
    endtask

    // Plan item 5: reset mid-frame returns to the marker.
    task automatic test_reset_midframe();
        link.iEn   = 1'b0;
        link.iMode = 2'd0;
        do_reset();
        link.iEn = 1'b1;
        repeat (1234) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (link.oD_Link !== 20'h0 || link.oValid !== 1'b0 || link.oSof !== 1'b0 ||
            link.oFrameCnt !== 16'd0) begin
            failures++;
            $display("[TB] FAIL midframe_reset got data=%h valid=%b sof=%b frames=%0d exp all zero",
                     link.oD_Link, link.oValid, link.oSof, link.oFrameCnt);
        end
        tick();
        checks++;
        if (link.oD_Link !== 20'hFFFFF || link.oSof !== 1'b1 || link.oFrameCnt !== 16'd1) begin
            failures++;
            $display("[TB] FAIL post_reset_marker got data=%h sof=%b frames=%0d exp data=fffff sof=1 frames=1",
                     link.oD_Link, link.oSof, link.oFrameCnt);
        end
        tick();
        checks++;
        if (link.oD_Link !== 20'h00010) begin
            failures++;
            $display("[TB] FAIL post_reset_word got=%h exp=%h", link.oD_Link, 20'h00010);
        end
    endtask

    // Walking-one wraps every 20 payload words.
    task automatic test_walking_one();
        logic [19:0] exp_word;
        link.iEn   = 1'b0;
        link.iMode = 2'd3;
        do_reset();
        link.iEn = 1'b1;
        tick();
        for (int k = 1; k <= 25; k++) begin
            exp_word = 20'h00001 << ((k - 1) % 20);
            tick();
            checks++;
            if (link.oD_Link !== exp_word) begin
                failures++;
                $display("[TB] FAIL walk_word k=%0d got=%h exp=%h", k, link.oD_Link, exp_word);
            end
        end
    endtask

    // PERIOD=2: marker and payload alternate back to back.
    task automatic test_back_to_back();
        logic [19:0] exp_word;
        link.iEn    = 1'b0;
        link2.iEn   = 1'b0;
        link2.iMode = 2'd0;
        link2.iFixed = '0;
        do_reset();
        link2.iEn = 1'b1;
        for (int k = 0; k < 6; k++) begin
            exp_word = (k % 2 == 0) ? 20'hFFFFF : 20'h00010;
            tick();
            checks++;
            if (link2.oD_Link !== exp_word || link2.oSof !== (k % 2 == 0)) begin
                failures++;
                $display("[TB] FAIL p2_word k=%0d got data=%h sof=%b exp data=%h sof=%b",
                         k, link2.oD_Link, link2.oSof, exp_word, (k % 2 == 0));
            end
            checks++;
            if (link2.oFrameCnt !== 16'((k / 2) + 1)) begin
                failures++;
                $display("[TB] FAIL p2_frame_cnt k=%0d got=%0d exp=%0d",
                         k, link2.oFrameCnt, (k / 2) + 1);
            end
        end
        link2.iEn = 1'b0;
    endtask

`ifdef LINK_TX_ERR_INJ_EN
    // Plan item 6 plus merging of requests made while idle.
    task automatic test_err_inj();
        link.iEn     = 1'b0;
        link.iMode   = 2'd0;
        link.iErrInj = 1'b0;
        do_reset();
        link.iEn = 1'b1;
        repeat (1999) tick();
        link.iErrInj = 1'b1;
        tick();
        link.iErrInj = 1'b0;
        checks++;
        if (link.oD_Link !== 20'h07CF0 || link.oErrCnt !== 16'd0) begin
            failures++;
            $display("[TB] FAIL inj_request_word got data=%h errs=%0d exp data=07cf0 errs=0",
                     link.oD_Link, link.oErrCnt);
        end
        tick();
        checks++;
        if (link.oD_Link !== 20'hFFFFF || link.oErrCnt !== 16'd0) begin
            failures++;
            $display("[TB] FAIL inj_marker got data=%h errs=%0d exp data=fffff errs=0",
                     link.oD_Link, link.oErrCnt);
        end
        tick();
        checks++;
        if (link.oD_Link !== 20'h00011 || link.oErrCnt !== 16'd1) begin
            failures++;
            $display("[TB] FAIL inj_word got data=%h errs=%0d exp data=00011 errs=1",
                     link.oD_Link, link.oErrCnt);
        end
        tick();
        checks++;
        if (link.oD_Link !== 20'h00020 || link.oErrCnt !== 16'd1) begin
            failures++;
            $display("[TB] FAIL inj_cleared got data=%h errs=%0d exp data=00020 errs=1",
                     link.oD_Link, link.oErrCnt);
        end
        link.iEn     = 1'b0;
        link.iErrInj = 1'b1;
        tick();
        tick();
        link.iErrInj = 1'b0;
        link.iEn     = 1'b1;
        tick();
        checks++;
        if (link.oD_Link !== 20'h00031 || link.oErrCnt !== 16'd2) begin
            failures++;
            $display("[TB] FAIL inj_merged got data=%h errs=%0d exp data=00031 errs=2",
                     link.oD_Link, link.oErrCnt);
        end
        tick();
        checks++;
        if (link.oD_Link !== 20'h00040 || link.oErrCnt !== 16'd2) begin
            failures++;
            $display("[TB] FAIL inj_merged_once got data=%h errs=%0d exp data=00040 errs=2",
                     link.oD_Link, link.oErrCnt);
        end
    endtask
`endif

    initial begin
        rst          = 1'b1;
        link.iEn     = 1'b0;
        link.iMode   = 2'd0;
        link.iFixed  = '0;
        link2.iEn    = 1'b0;
        link2.iMode  = 2'd0;
        link2.iFixed = '0;
`ifdef LINK_TX_ERR_INJ_EN
        link.iErrInj  = 1'b0;
        link2.iErrInj = 1'b0;
`endif
        test_reset();
        test_ramp();
        test_prbs();
        test_mode_change();
        test_enable_hold();
        test_reset_midframe();
        test_walking_one();
        test_back_to_back();
`ifdef LINK_TX_ERR_INJ_EN
        test_err_inj();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
